// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
//   src_e     : source ID stored per outstanding read (0 = ibus, 1 = dbus)
//   bus_req_t : request fields carried to memory (write, wstrb, addr, wdata)
//   XLEN      : data/address width
//   ID_W      : width of the stored source ID
package mem_arb_pkg;

    localparam int XLEN = 32;
    localparam int ID_W = 1;

    typedef enum logic {
        SRC_IBUS = 1'b0,
        SRC_DBUS = 1'b1
    } src_e;

    typedef struct packed {
        logic                write;
        logic [XLEN/8-1:0]   wstrb;
        logic [XLEN-1:0]     addr;
        logic [XLEN-1:0]     wdata;
    } bus_req_t;

endpackage

// File: rtl/resp_id_fifo.sv
// In-order FIFO of source IDs for reads accepted by memory but not yet answered.
// Ports:
//   clk, rst_b : clock, synchronous active-low reset
//   push, din  : store din (ignored when full)
//   pop        : drop head entry (ignored when empty)
//   dout       : head entry
//   full/empty : occupancy flags
module resp_id_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Pointers wrap explicitly so non-power-of-2 depths also behave.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + AW'(1);
        end
    endfunction

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            mem_r    <= '{default: '0};
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch read port (ibus) and the data port
// (dbus). Grant is combinational with dbus priority; reads are tracked in an
// ID FIFO so responses are steered back in order to the issuing port.
// Ports:
//   clk, rst_b          : clock, synchronous active-low reset
//   ibus_*              : fetch read port (req/addr in, ready/rvalid/rdata out)
//   dbus_*              : data port (req/write/wstrb/addr/wdata in, ready/rvalid/rdata out)
//   bus_*               : memory side (req/write/wstrb/addr/wdata out, ready/rvalid/rdata in)
//   arb_resp_err        : sticky flag, response arrived with nothing outstanding
// Optional build macro MEM_ARB_STARVE_GUARD_EN: after STARVE_LIMIT dbus
// acceptances while ibus waits, ibus gets priority until it is accepted.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int OUTSTANDING_DEPTH = 2,
    parameter int STARVE_LIMIT      = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              ibus_req,
    input  logic [XLEN-1:0]   ibus_addr,
    output logic              ibus_ready,
    output logic              ibus_rvalid,
    output logic [XLEN-1:0]   ibus_rdata,
    input  logic              dbus_req,
    input  logic              dbus_write,
    input  logic [XLEN/8-1:0] dbus_wstrb,
    input  logic [XLEN-1:0]   dbus_addr,
    input  logic [XLEN-1:0]   dbus_wdata,
    output logic              dbus_ready,
    output logic              dbus_rvalid,
    output logic [XLEN-1:0]   dbus_rdata,
    output logic              bus_req,
    output logic              bus_write,
    output logic [XLEN/8-1:0] bus_wstrb,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              arb_resp_err
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic            full_s;
    logic            empty_s;
    logic [ID_W-1:0] head_id_s;
    src_e            head_src_s;
    logic            ibus_elig_s;
    logic            dbus_elig_s;
    logic            grant_i_s;
    logic            grant_d_s;
    logic            ibus_acc_s;
    logic            dbus_acc_s;
    logic            push_s;
    logic            pop_s;
    logic [ID_W-1:0] push_id_s;
    logic [SCW-1:0]  starve_cnt_s;
    logic            force_ibus_s;
    bus_req_t        bus_sel_s;
    logic            resp_err_r;

    // Full blocks every read, independent of a same-cycle pop, so bus_rvalid
    // never reaches bus_req.
    assign ibus_elig_s = ibus_req & ~full_s;
    assign dbus_elig_s = dbus_req & (dbus_write | ~full_s);

    assign force_ibus_s = (starve_cnt_s == SCW'(STARVE_LIMIT));

    // Port selection: dbus wins unless the starvation guard hands ibus priority.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (dbus_elig_s && !(force_ibus_s && ibus_elig_s)) begin
            grant_d_s = 1'b1;
        end else if (ibus_elig_s) begin
            grant_i_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Request field mux; ibus is read-only so its write fields are zero.
    always_comb begin
        bus_sel_s = '0;
        if (grant_d_s) begin
            bus_sel_s.write = dbus_write;
            bus_sel_s.wstrb = dbus_wstrb;
            bus_sel_s.addr  = dbus_addr;
            bus_sel_s.wdata = dbus_wdata;
        end else if (grant_i_s) begin
            bus_sel_s.addr  = ibus_addr;
        end else begin
            bus_sel_s = '0;
        end
    end

    assign bus_req    = grant_d_s | grant_i_s;
    assign bus_write  = bus_sel_s.write;
    assign bus_wstrb  = bus_sel_s.wstrb;
    assign bus_addr   = bus_sel_s.addr;
    assign bus_wdata  = bus_sel_s.wdata;

    assign ibus_ready = grant_i_s & bus_ready;
    assign dbus_ready = grant_d_s & bus_ready;
    assign ibus_acc_s = ibus_req & ibus_ready;
    assign dbus_acc_s = dbus_req & dbus_ready;

    assign push_s    = ibus_acc_s | (dbus_acc_s & ~dbus_write);
    assign push_id_s = grant_d_s ? ID_W'(SRC_DBUS) : ID_W'(SRC_IBUS);
    assign pop_s     = bus_rvalid & ~empty_s;

    resp_id_fifo #(
        .DEPTH (OUTSTANDING_DEPTH),
        .W     (ID_W)
    ) u_resp_id_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_id_s),
        .dout  (head_id_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign head_src_s  = src_e'(head_id_s);
    assign ibus_rvalid = pop_s & (head_src_s == SRC_IBUS);
    assign dbus_rvalid = pop_s & (head_src_s == SRC_DBUS);
    assign ibus_rdata  = bus_rdata;
    assign dbus_rdata  = bus_rdata;

    // Sticky flag for a response that has no matching outstanding read.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            resp_err_r <= 1'b0;
        end else if (bus_rvalid && empty_s) begin
            resp_err_r <= 1'b1;
        end else begin
            resp_err_r <= resp_err_r;
        end
    end

    assign arb_resp_err = resp_err_r;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [SCW-1:0] starve_cnt_r;

    // Counts dbus wins while ibus was eligible and waiting; saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            starve_cnt_r <= '0;
        end else if (!ibus_req || ibus_acc_s) begin
            starve_cnt_r <= '0;
        end else if (dbus_acc_s && ibus_elig_s && (starve_cnt_r != SCW'(STARVE_LIMIT))) begin
            starve_cnt_r <= starve_cnt_r + SCW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign starve_cnt_s = starve_cnt_r;
`else
    // Guard disabled: counter tied to zero, so force_ibus_s folds to 0 for any
    // legal limit (>= 1) and dbus keeps strict priority.
    assign starve_cnt_s = '0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter. Stimulus pushes expected
// bus acceptances and read responses into queues; a negedge monitor pops and
// compares whenever the DUT accepts a request or presents a response.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic            port;   // 0 = ibus, 1 = dbus
        logic [XLEN-1:0] data;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              ibus_req;
    logic [XLEN-1:0]   ibus_addr;
    logic              ibus_ready;
    logic              ibus_rvalid;
    logic [XLEN-1:0]   ibus_rdata;
    logic              dbus_req;
    logic              dbus_write;
    logic [XLEN/8-1:0] dbus_wstrb;
    logic [XLEN-1:0]   dbus_addr;
    logic [XLEN-1:0]   dbus_wdata;
    logic              dbus_ready;
    logic              dbus_rvalid;
    logic [XLEN-1:0]   dbus_rdata;
    logic              bus_req;
    logic              bus_write;
    logic [XLEN/8-1:0] bus_wstrb;
    logic [XLEN-1:0]   bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_ready;
    logic              bus_rvalid;
    logic [XLEN-1:0]   bus_rdata;
    logic              arb_resp_err;

    int checks   = 0;
    int failures = 0;

    bus_req_t exp_bus_q[$];
    resp_t    exp_resp_q[$];

    mem_bus_arbiter #(.OUTSTANDING_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_b(rst_b),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ready(ibus_ready),
        .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
        .dbus_req(dbus_req), .dbus_write(dbus_write), .dbus_wstrb(dbus_wstrb),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_ready(dbus_ready),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .bus_req(bus_req), .bus_write(bus_write), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .arb_resp_err(arb_resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ibus_req   = 1'b0; ibus_addr  = '0;
        dbus_req   = 1'b0; dbus_write = 1'b0; dbus_wstrb = '0;
        dbus_addr  = '0;   dbus_wdata = '0;
        bus_ready  = 1'b1; bus_rvalid = 1'b0; bus_rdata  = '0;
    endtask

    function automatic bus_req_t rd(input logic [XLEN-1:0] a);
        bus_req_t r;
        r = '0;
        r.addr = a;
        return r;
    endfunction

    function automatic bus_req_t wr(input logic [3:0] s, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
        bus_req_t r;
        r.write = 1'b1; r.wstrb = s; r.addr = a; r.wdata = d;
        return r;
    endfunction

    // Monitor: compare every bus acceptance and every response against the queues.
    always @(negedge clk) begin
        if (bus_req && bus_ready) begin
            if (exp_bus_q.size() == 0) begin
                chk("bus_unexpected_accept", bus_addr, '1);
            end else begin
                bus_req_t e;
                e = exp_bus_q.pop_front();
                chk("bus_write", {31'd0, bus_write}, {31'd0, e.write});
                chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, e.wstrb});
                chk("bus_addr",  bus_addr,  e.addr);
                chk("bus_wdata", bus_wdata, e.wdata);
            end
        end
        if (ibus_rvalid || dbus_rvalid) begin
            if (ibus_rvalid && dbus_rvalid) begin
                chk("rvalid_both", 32'd1, 32'd0);
            end else if (exp_resp_q.size() == 0) begin
                chk("resp_unexpected", bus_rdata, '1);
            end else begin
                resp_t e;
                e = exp_resp_q.pop_front();
                chk("resp_port", {31'd0, dbus_rvalid}, {31'd0, e.port});
                chk("resp_data", dbus_rvalid ? dbus_rdata : ibus_rdata, e.data);
            end
        end
    end

    initial begin
        idle();
        rst_b = 1'b0;
        cyc(); cyc();
        rst_b = 1'b1;

        // Reset / idle state and stray response
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_ibus_rvalid", {31'd0, ibus_rvalid}, 32'd0);
        chk("rst_dbus_rvalid", {31'd0, dbus_rvalid}, 32'd0);
        chk("rst_err", {31'd0, arb_resp_err}, 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_0BAD;
        #1;
        chk("stray_no_ivalid", {31'd0, ibus_rvalid}, 32'd0);
        chk("stray_no_dvalid", {31'd0, dbus_rvalid}, 32'd0);
        cyc();
        bus_rvalid = 1'b0;
        chk("stray_err_set", {31'd0, arb_resp_err}, 32'd1);
        cyc(); cyc();
        chk("stray_err_sticky", {31'd0, arb_resp_err}, 32'd1);
        rst_b = 1'b0; cyc(); rst_b = 1'b1;
        chk("err_cleared", {31'd0, arb_resp_err}, 32'd0);

        // Simultaneous requests: dbus first, then ibus
        ibus_req = 1'b1; ibus_addr = 32'h100;
        dbus_req = 1'b1; dbus_write = 1'b0; dbus_addr = 32'h2000;
        exp_bus_q.push_back(rd(32'h2000));
        #1;
        chk("prio_dbus_ready", {31'd0, dbus_ready}, 32'd1);
        chk("prio_ibus_ready", {31'd0, ibus_ready}, 32'd0);
        cyc();
        dbus_req = 1'b0; dbus_write = 1'b1; dbus_wstrb = 4'hF; dbus_wdata = 32'hFFFF_FFFF;
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        exp_resp_q.push_back('{1'b1, 32'hDEAD_BEEF});
        exp_bus_q.push_back(rd(32'h100));
        #1;
        chk("next_ibus_ready", {31'd0, ibus_ready}, 32'd1);
        cyc();
        ibus_req = 1'b0;
        bus_rdata = 32'h0000_0100;
        exp_resp_q.push_back('{1'b0, 32'h0000_0100});
        cyc();
        idle();

        // FIFO full blocks reads but not writes
        ibus_req = 1'b1; ibus_addr = 32'h200;
        exp_bus_q.push_back(rd(32'h200));
        cyc();
        ibus_addr = 32'h204;
        exp_bus_q.push_back(rd(32'h204));
        cyc();
        ibus_addr = 32'h208;
        dbus_req = 1'b1; dbus_write = 1'b1; dbus_addr = 32'h40;
        dbus_wstrb = 4'h3; dbus_wdata = 32'hCAFE_F00D;
        exp_bus_q.push_back(wr(4'h3, 32'h40, 32'hCAFE_F00D));
        #1;
        chk("full_ibus_ready", {31'd0, ibus_ready}, 32'd0);
        chk("full_store_ready", {31'd0, dbus_ready}, 32'd1);
        cyc();
        dbus_req = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hA0;
        exp_resp_q.push_back('{1'b0, 32'hA0});
        #1;
        chk("full_pop_blocks", {31'd0, ibus_ready}, 32'd0);
        chk("full_no_bus_req", {31'd0, bus_req}, 32'd0);
        cyc();
        bus_rvalid = 1'b0;
        exp_bus_q.push_back(rd(32'h208));
        #1;
        chk("after_pop_ready", {31'd0, ibus_ready}, 32'd1);
        cyc();
        ibus_req = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hA4;
        exp_resp_q.push_back('{1'b0, 32'hA4});
        cyc();
        bus_rdata = 32'hA8;
        exp_resp_q.push_back('{1'b0, 32'hA8});
        cyc();
        idle();

        // Interleaved reads with simultaneous push/pop
        ibus_req = 1'b1; ibus_addr = 32'h300;
        exp_bus_q.push_back(rd(32'h300));
        cyc();
        ibus_req = 1'b0;
        dbus_req = 1'b1; dbus_write = 1'b0; dbus_addr = 32'h3000;
        bus_rvalid = 1'b1; bus_rdata = 32'h11;
        exp_bus_q.push_back(rd(32'h3000));
        exp_resp_q.push_back('{1'b0, 32'h11});
        cyc();
        dbus_req = 1'b0;
        ibus_req = 1'b1; ibus_addr = 32'h304;
        bus_rdata = 32'h22;
        exp_bus_q.push_back(rd(32'h304));
        exp_resp_q.push_back('{1'b1, 32'h22});
        cyc();
        ibus_req = 1'b0;
        bus_rdata = 32'h33;
        exp_resp_q.push_back('{1'b0, 32'h33});
        cyc();
        idle();
        chk("interleave_no_err", {31'd0, arb_resp_err}, 32'd0);

        // Starvation: both ports held requesting
        ibus_req = 1'b1; ibus_addr = 32'h500;
        dbus_req = 1'b1; dbus_write = 1'b1; dbus_addr = 32'h80; dbus_wstrb = 4'hF;
        for (int k = 0; k < 6; k++) begin
            logic exp_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_i = (k == 4);
`else
            exp_i = 1'b0;
`endif
            dbus_wdata = 32'(k);
            if (exp_i) exp_bus_q.push_back(rd(32'h500));
            else       exp_bus_q.push_back(wr(4'hF, 32'h80, 32'(k)));
            #1;
            chk($sformatf("starve_ibus_ready_%0d", k), {31'd0, ibus_ready}, {31'd0, exp_i});
            chk($sformatf("starve_dbus_ready_%0d", k), {31'd0, dbus_ready}, {31'd0, ~exp_i});
            cyc();
        end
        idle();
`ifdef MEM_ARB_STARVE_GUARD_EN
        bus_rvalid = 1'b1; bus_rdata = 32'h55;
        exp_resp_q.push_back('{1'b0, 32'h55});
        cyc();
        idle();
`endif

        // Reset with two reads outstanding, then a late response
        ibus_req = 1'b1; ibus_addr = 32'h600;
        exp_bus_q.push_back(rd(32'h600));
        cyc();
        ibus_addr = 32'h604;
        exp_bus_q.push_back(rd(32'h604));
        cyc();
        idle();
        rst_b = 1'b0; cyc(); rst_b = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h66;
        #1;
        chk("late_no_ivalid", {31'd0, ibus_rvalid}, 32'd0);
        chk("late_no_dvalid", {31'd0, dbus_rvalid}, 32'd0);
        cyc();
        bus_rvalid = 1'b0;
        chk("late_err_set", {31'd0, arb_resp_err}, 32'd1);
        ibus_req = 1'b1; ibus_addr = 32'h700;
        exp_bus_q.push_back(rd(32'h700));
        #1;
        chk("post_rst_not_full", {31'd0, ibus_ready}, 32'd1);
        cyc();
        ibus_req = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h77;
        exp_resp_q.push_back('{1'b0, 32'h77});
        cyc();
        idle();
        cyc();
        chk("late_err_sticky", {31'd0, arb_resp_err}, 32'd1);

        chk("bus_q_drained",  32'(exp_bus_q.size()),  32'd0);
        chk("resp_q_drained", 32'(exp_resp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory bus between the instruction-fetch read port (ibus) and the EX-stage data port (dbus).
- Requests on both ports follow the same req/ready handshake that EX uses toward data RAM.
- Decides which requester is granted each cycle and tracks outstanding reads in order.
- Steers each read response back to the requester that issued it.

Parameters:
- OUTSTANDING_DEPTH, 2, maximum number of accepted reads awaiting bus_rvalid (power of 2, ≥1).
- STARVE_LIMIT, 4, number of consecutive dbus grants while ibus is waiting before ibus is forced a grant.

Ports:
- clk  in  1  clock
- rst_b  in  1  synchronous active-low reset
- ibus_req  in  1  fetch read request
- ibus_addr  in  XLEN  fetch address
- ibus_ready  out  1  fetch request accepted this cycle
- ibus_rvalid  out  1  fetch read data valid
- ibus_rdata  out  XLEN  fetch read data
- dbus_req  in  1  data request
- dbus_write  in  1  1 = store, 0 = load
- dbus_wstrb  in  XLEN/8  byte strobes
- dbus_addr  in  XLEN  data address
- dbus_wdata  in  XLEN  store data
- dbus_ready  out  1  data request accepted this cycle
- dbus_rvalid  out  1  load data valid
- dbus_rdata  out  XLEN  load data
- bus_req  out  1  request to memory
- bus_write  out  1  write request
- bus_wstrb  out  XLEN/8  byte strobes
- bus_addr  out  XLEN  address
- bus_wdata  out  XLEN  write data
- bus_ready  in  1  memory accepts the request
- bus_rvalid  in  1  read response valid
- bus_rdata  in  XLEN  read response data
- arb_resp_err  out  1  sticky: response received with nothing outstanding

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_b). All state clears when rst_b = 0 at a clk edge.
- Reset values:
  - FIFO empty, count 0, starve counter 0, arb_resp_err 0.
  - ibus_rvalid and dbus_rvalid read 0 (FIFO empty).
  - Ready outputs follow their combinational equations.
- Grant (combinational, zero-cycle pass-through):
  - A read is eligible only if the FIFO is not full.
  - dbus writes are always eligible; ibus is read-only.
  - Default priority is dbus over ibus. The forced-ibus rule is described under Optional Feature.
  - bus_* carries the granted port's fields. Writes from ibus are impossible: bus_write = 0, bus_wstrb = 0, bus_wdata = 0 when ibus is granted.
  - bus_req = granted port's req. Nothing is granted when no port is eligible.
  - x_ready = granted(x) & bus_ready. A request is accepted when x_req & x_ready.
- Full condition: FIFO full blocks all read grants, even if bus_rvalid pops in the same cycle. This keeps bus_rvalid off any path to bus_req.
- Outstanding FIFO:
  - Push a 1-bit source ID (0 = ibus, 1 = dbus) on every accepted read. Writes do not push.
  - Pop on bus_rvalid when not empty. Push and pop in the same cycle are allowed; count is unchanged.
  - Pointers wrap modulo OUTSTANDING_DEPTH.
- Response steering (combinational):
  - ibus_rvalid = bus_rvalid & ~empty & head == 0; dbus_rvalid likewise for head == 1.
  - Both rdata outputs = bus_rdata.
  - bus_rvalid while empty is dropped and sets arb_resp_err until reset.
- Responses are in order. Minimum read latency is 1 cycle after acceptance; a same-cycle response is illegal.
- Reset mid-operation discards outstanding entries. The memory side must be reset together with the arbiter; stray late responses flag arb_resp_err.
- Requesters must hold req and the request fields stable until ready.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter of width $clog2(STARVE_LIMIT+1) increments on each accepted dbus request while ibus_req = 1 and ibus is eligible.
  - The counter clears on an accepted ibus request, or when ibus_req = 0.
  - When the count reaches STARVE_LIMIT, priority flips to ibus until the next ibus acceptance, then clears.
- Undefined: strict dbus priority; the counter logic is absent.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic {SRC_IBUS = 0, SRC_DBUS = 1} src_e
  - typedef of the bus request struct: write, wstrb, addr, wdata
  - localparams for ID width
- Sub-module resp_id_fifo:
  - Parameters: DEPTH, W.
  - Ports: push, pop, din, dout, full, empty.
  - Synchronous active-low reset.

Test Plan:
- Reset then idle: bus_req = 0, both rvalid = 0, arb_resp_err = 0. bus_rvalid = 1 while idle → arb_resp_err = 1 and stays 1 until rst_b = 0.
- Simultaneous ibus_req (addr 0x100) and dbus load (addr 0x2000), bus_ready = 1 → dbus granted first. Response for 0x2000 returns on dbus_rvalid with rdata 0xDEADBEEF; ibus is granted the next cycle.
- Two ibus reads accepted with DEPTH = 2 and no response yet → third ibus_req sees ibus_ready = 0. dbus store to 0x40 with wstrb 0x3 is still granted (ibus_ready = 0, dbus_ready = 1). After one bus_rvalid, the next read is granted.
- Interleaved ibus, dbus, ibus reads with responses 0x11, 0x22, 0x33 → 0x11 appears on ibus, 0x22 on dbus, 0x33 on ibus, in order. Simultaneous push/pop keeps count correct.
- MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT = 4, dbus_req and ibus_req held at 1 → 4 dbus acceptances, then 1 ibus acceptance, then dbus resumes. Without the macro, ibus is never granted.
- rst_b = 0 with 2 reads outstanding → FIFO empty after reset. A late bus_rvalid sets arb_resp_err and drives no rvalid to either port.
